// File: rtl/softmax_exp_accum.sv
// rtl/softmax_exp_accum.sv - buffers one vector of fp16 exp() results, sums them in fixed point, replays them with the sum
//
// Collects VEC_LEN floats from exp_taylor and adds each one, converted to
// unsigned fixed point, into a saturating accumulator. It then replays the
// stored words unchanged, with the final sum attached, to the normalising
// divider.
//
// Ports:
//   aclk           clock, rising edge
//   aresetn        synchronous reset, active HIGH despite the name
//   s_axis_tdata   float input word (EXP+FRA+1 bits)
//   s_axis_tvalid  input valid
//   s_axis_tready  input ready, only high while collecting
//   m_axis_tdata   buffered element, bit-exact copy of the input
//   m_axis_sum     fixed-point sum of the whole vector (ACC_FRAC fraction bits)
//   m_axis_tvalid  output valid, only high while draining
//   m_axis_tready  downstream ready
//   m_axis_tlast   last element of the vector
//   ovf            sum saturated, or a negative/inf/NaN input was seen this vector
module softmax_exp_accum #(
  parameter int EXP      = 5,
  parameter int FRA      = 10,
  parameter int VEC_LEN  = 16,
  parameter int ACC_W    = 32,
  parameter int ACC_FRAC = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [EXP+FRA:0]     s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [EXP+FRA:0]     m_axis_tdata,
  output logic [ACC_W-1:0]     m_axis_sum,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 ovf
);

  localparam int W      = EXP + FRA + 1;
  localparam int BIAS   = (1 << (EXP - 1)) - 1;
  // Left-shift amount applied to {1,f} is e - SH_OFF.
  localparam int SH_OFF = BIAS + FRA - ACC_FRAC;
  localparam int MAX_E  = (1 << EXP) - 1;
  // Wide enough to hold {1,f} at the largest possible left shift, so any
  // bit landing above ACC_W is seen and turned into saturation.
  localparam int WIDE_W = ACC_W + FRA + 1 + MAX_E;
  localparam int IDX_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t           state;
  logic [W-1:0]     mem [VEC_LEN];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [ACC_W-1:0] acc;

  logic              in_sign;
  logic [EXP-1:0]    in_exp;
  logic [FRA-1:0]    in_fra;
  logic [WIDE_W-1:0] mant_wide;
  logic [WIDE_W-1:0] shifted;
  logic [ACC_W-1:0]  fix_val;
  logic              fix_bad;
  logic [ACC_W:0]    sum_ext;
  logic [ACC_W-1:0]  sum_sat;

  // Float to fixed conversion of the incoming word.
  always_comb begin
    in_sign   = s_axis_tdata[W-1];
    in_exp    = s_axis_tdata[W-2:FRA];
    in_fra    = s_axis_tdata[FRA-1:0];
    mant_wide = WIDE_W'({1'b1, in_fra});
    shifted   = '0;
    fix_val   = '0;
    fix_bad   = 1'b0;
    if (in_exp == '0) begin
      fix_val = '0;                      // zero and subnormals contribute nothing
    end else if (in_sign) begin
      fix_bad = 1'b1;                    // exp() is never negative
    end else if (in_exp == '1) begin
      fix_val = '1;                      // inf / NaN
      fix_bad = 1'b1;
    end else begin
      if (int'(in_exp) >= SH_OFF)
        shifted = mant_wide << (int'(in_exp) - SH_OFF);
      else
        shifted = mant_wide >> (SH_OFF - int'(in_exp));
      if (|shifted[WIDE_W-1:ACC_W]) begin
        fix_val = '1;
        fix_bad = 1'b1;
      end else begin
        fix_val = shifted[ACC_W-1:0];
      end
    end
    sum_ext = {1'b0, acc} + {1'b0, fix_val};
    sum_sat = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
  end

  always_ff @(posedge aclk) begin
    if (aresetn) begin
      state         <= COLLECT;
      wr_idx        <= '0;
      rd_idx        <= '0;
      acc           <= '0;
      ovf           <= 1'b0;
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          s_axis_tready <= 1'b1;
          if (s_axis_tvalid && s_axis_tready) begin
            mem[wr_idx] <= s_axis_tdata;
            acc         <= sum_sat;
            ovf         <= ovf | fix_bad | sum_ext[ACC_W];
            if (wr_idx == LAST_IDX) begin
              state         <= DRAIN;
              wr_idx        <= '0;
              s_axis_tready <= 1'b0;
              m_axis_tvalid <= 1'b1;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (m_axis_tready) begin
            if (rd_idx == LAST_IDX) begin
              state         <= COLLECT;
              rd_idx        <= '0;
              acc           <= '0;
              ovf           <= 1'b0;
              m_axis_tvalid <= 1'b0;
              s_axis_tready <= 1'b1;
            end else begin
              rd_idx <= rd_idx + 1'b1;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  // Outputs are pure functions of registers, so they hold while stalled;
  // they read as zero whenever nothing is being offered.
  assign m_axis_tdata = m_axis_tvalid ? mem[rd_idx] : '0;
  assign m_axis_sum   = m_axis_tvalid ? acc : '0;
  assign m_axis_tlast = m_axis_tvalid && (rd_idx == LAST_IDX);

endmodule

// File: tb/tb_softmax_exp_accum.sv
// tb/tb_softmax_exp_accum.sv - scoreboard bench for softmax_exp_accum with VEC_LEN=4
module tb_softmax_exp_accum;

  localparam int VL = 4;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic [15:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [15:0] m_axis_tdata;
  logic [31:0] m_axis_sum;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        ovf;

  softmax_exp_accum #(.EXP(5), .FRA(10), .VEC_LEN(VL), .ACC_W(32), .ACC_FRAC(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_sum(m_axis_sum), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .ovf(ovf)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [15:0] data;
    logic [31:0] sum;
    logic        last;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] vin [VL];
  int          n_vec  = 0;
  int          n_fail = 0;

  // Reference: value of an fp16 in 16.16 fixed point, truncated, 64-bit wide.
  function automatic void ref_fix(input logic [15:0] x, output logic [63:0] v, output bit bad);
    int          e;
    logic [63:0] m;
    e   = int'(x[14:10]);
    m   = {53'd0, 1'b1, x[9:0]};
    v   = 64'd0;
    bad = 1'b0;
    if (e == 0) v = 64'd0;
    else if (x[15]) bad = 1'b1;
    else if (e == 31) begin v = 64'hFFFF_FFFF; bad = 1'b1; end
    else begin
      if (e >= 9) v = m << (e - 9);
      else v = m >> (9 - e);
      if (v > 64'hFFFF_FFFF) begin v = 64'hFFFF_FFFF; bad = 1'b1; end
    end
  endfunction

  // Drives n beats of vin[]; when n==VL the expected drain is queued.
  task automatic send_vec(input int n, input bit gaps);
    logic [63:0] s, v;
    bit          o, b;
    int          guard;
    s = 64'd0;
    o = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(1, 0) == 0) begin
          s_axis_tvalid = 1'b0;
          s_axis_tdata  = 16'($urandom);
          @(posedge aclk); #1;
        end
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = vin[i];
      guard = 0;
      do begin
        @(negedge aclk);
        guard++;
      end while (s_axis_tready !== 1'b1 && guard < 50);
      n_vec++;
      if (s_axis_tready !== 1'b1) begin
        n_fail++;
        $display("FAIL in_ready_timeout beat %0d: s_axis_tready=%b required 1", i, s_axis_tready);
      end
      @(posedge aclk); #1;
      ref_fix(vin[i], v, b);
      s = s + v;
      if (s > 64'hFFFF_FFFF) begin s = 64'hFFFF_FFFF; o = 1'b1; end
      o = o | b;
    end
    s_axis_tvalid = 1'b0;
    if (n == VL)
      for (int i = 0; i < VL; i++)
        exp_q.push_back('{data: vin[i], sum: s[31:0], last: (i == VL - 1), ovf: o});
  endtask

  // Drains one vector; toggle=1 alternates m_axis_tready starting high.
  task automatic drain(input bit toggle);
    int          got, cyc;
    bit          stalled;
    logic [15:0] sv_d;
    logic [31:0] sv_s;
    logic        sv_l;
    exp_t        e;
    got = 0; cyc = 0; stalled = 1'b0;
    sv_d = '0; sv_s = '0; sv_l = 1'b0;
    while (got < VL && cyc < 100) begin
      m_axis_tready = toggle ? (cyc % 2 == 0) : 1'b1;
      @(negedge aclk);
      if (cyc == 0) begin
        n_vec++;
        if (m_axis_tvalid !== 1'b1) begin
          n_fail++;
          $display("FAIL latency: m_axis_tvalid=%b required 1 one cycle after last input", m_axis_tvalid);
        end
      end
      if (stalled) begin
        n_vec++;
        if (m_axis_tdata !== sv_d || m_axis_sum !== sv_s || m_axis_tlast !== sv_l) begin
          n_fail++;
          $display("FAIL stall_hold: data=%h sum=%h last=%b required %h %h %b",
                   m_axis_tdata, m_axis_sum, m_axis_tlast, sv_d, sv_s, sv_l);
        end
      end
      if (m_axis_tvalid === 1'b1) begin
        n_vec++;
        if (s_axis_tready !== 1'b0) begin
          n_fail++;
          $display("FAIL drain_in_ready: s_axis_tready=%b required 0", s_axis_tready);
        end
        if (m_axis_tready) begin
          stalled = 1'b0;
          got++;
          n_vec++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL extra_output: data=%h with no expected entry", m_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            if (m_axis_tdata !== e.data || m_axis_sum !== e.sum ||
                m_axis_tlast !== e.last || ovf !== e.ovf) begin
              n_fail++;
              $display("FAIL output %0d: data=%h sum=%h last=%b ovf=%b required %h %h %b %b",
                       got, m_axis_tdata, m_axis_sum, m_axis_tlast, ovf,
                       e.data, e.sum, e.last, e.ovf);
            end
          end
        end else begin
          stalled = 1'b1;
          sv_d = m_axis_tdata; sv_s = m_axis_sum; sv_l = m_axis_tlast;
        end
      end
      @(posedge aclk); #1;
      cyc++;
    end
    m_axis_tready = 1'b1;
    @(negedge aclk);
    n_vec++;
    if (got != VL || m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_end: outputs=%0d tvalid=%b s_ready=%b required %0d 0 1",
               got, m_axis_tvalid, s_axis_tready, VL);
    end
    @(posedge aclk); #1;
  endtask

  task automatic set_vin(input logic [15:0] a, b, c, d);
    vin[0] = a; vin[1] = b; vin[2] = c; vin[3] = d;
  endtask

  task automatic test_reset;
    aresetn = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    n_vec++;
    if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tdata !== 16'h0 ||
        m_axis_sum !== 32'h0 || m_axis_tlast !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: s_rdy=%b m_vld=%b data=%h sum=%h last=%b ovf=%b required all 0",
               s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_sum, m_axis_tlast, ovf);
    end
    @(posedge aclk); #1;
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    n_vec++;
    if (s_axis_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: s_axis_tready=%b required 1", s_axis_tready);
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_ones;
    set_vin(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    send_vec(VL, 1'b0);
    drain(1'b0);
  endtask

  task automatic test_mixed;
    set_vin(16'h4000, 16'h3800, 16'h3C00, 16'h0000);
    send_vec(VL, 1'b0);
    drain(1'b0);
  endtask

  task automatic test_inf_then_clear;
    set_vin(16'h7C00, 16'h3C00, 16'h3C00, 16'h3C00);
    send_vec(VL, 1'b0);
    drain(1'b0);
    set_vin(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    send_vec(VL, 1'b0);
    drain(1'b0);
  endtask

  task automatic test_negative;
    set_vin(16'hBC00, 16'h3C00, 16'h0001, 16'h4400);
    send_vec(VL, 1'b0);
    drain(1'b0);
  endtask

  task automatic test_backpressure;
    set_vin(16'h3C00, 16'h4200, 16'h3555, 16'h5A00);
    send_vec(VL, 1'b0);
    drain(1'b1);
  endtask

  task automatic test_gaps;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < VL; i++) vin[i] = 16'($urandom_range(16'h5FFF, 0));
      send_vec(VL, 1'b1);
      drain(k[0]);
    end
  endtask

  task automatic test_reset_mid_collect;
    set_vin(16'h4000, 16'h4000, 16'h0000, 16'h0000);
    send_vec(2, 1'b0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    aresetn = 1'b0;
    @(negedge aclk);
    n_vec++;
    if (m_axis_tvalid !== 1'b0 || m_axis_sum !== 32'h0) begin
      n_fail++;
      $display("FAIL post_reset_idle: m_axis_tvalid=%b sum=%h required 0 0", m_axis_tvalid, m_axis_sum);
    end
    @(posedge aclk); #1;
    set_vin(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    send_vec(VL, 1'b0);
    drain(1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      n_vec++;
      if (m_axis_tvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL extra_after_reset: m_axis_tvalid=%b required 0", m_axis_tvalid);
      end
    end
    @(posedge aclk); #1;
  endtask

  initial begin
    test_reset;
    test_ones;
    test_mixed;
    test_inf_then_clear;
    test_negative;
    test_backpressure;
    test_gaps;
    test_reset_mid_collect;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expected: %0d entries never produced, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
